potato2_control: RTL and testbench
==================================

POTATO2_CONTROL -- requirements
Module: potato2_control

Interface
REQ-001 Parameter DEPTH_W, default 8: width of the loop-nesting counter; legal range 2..16.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 run_en  input  1  1 = execute/skip; 0 = freeze (no state change, all pulse outputs 0).
REQ-005 ioready  input  1  external I/O ready for '.' or ','.
REQ-006 zeroflag  input  1  1 = current data cell is zero.
REQ-007 instruction  input  4  opcode at current PC.
REQ-008 pc_inc  output  1  advance PC by one at next edge.
REQ-009 pc_dec  output  1  retreat PC by one at next edge.
REQ-010 cmd_data_inc, cmd_data_dec, cmd_ptr_inc, cmd_ptr_dec, cmd_out, cmd_in  output  1 each  one-cycle datapath strobes.
REQ-011 halted  output  1  level, core stopped by HALT opcode.
REQ-012 error  output  1  level, nesting counter overflow.
REQ-013 depth  output  DEPTH_W  current loop-nesting count.

Function
REQ-014 Opcodes: 0x0 NOP, 0x1 '+', 0x2 '-', 0x3 '>', 0x4 '<', 0x5 '[', 0x6 ']', 0x7 '.', 0x8 ',', 0xF HALT; 0x9-0xE decode as NOP.
REQ-015 States: RESET, RUN, SKIP_FWD, SKIP_BACK, HALT, ERROR; state registered, outputs combinational from state and inputs.
REQ-016 pc_inc and pc_dec never both 1; at most one cmd_* strobe is 1 in any cycle.
REQ-017 RESET: all outputs 0, depth 0; next state RUN unconditionally (one idle cycle after reset release).
REQ-018 RUN, NOP/0x9-0xE: pc_inc=1 only.
REQ-019 RUN, 0x1-0x4: matching cmd_* strobe and pc_inc in the same cycle; zero latency.
REQ-020 RUN, '.': if ioready=1, cmd_out=1 and pc_inc=1; if ioready=0, all outputs 0 and state/PC hold (stall, unbounded).
REQ-021 RUN, ',': as REQ-020 with cmd_in.
REQ-022 RUN, '[': zeroflag=0 -> pc_inc only; zeroflag=1 -> pc_inc, depth<=1, next SKIP_FWD.
REQ-023 RUN, ']': zeroflag=1 -> pc_inc only; zeroflag=0 -> pc_dec, depth<=1, next SKIP_BACK.
REQ-024 SKIP_FWD: pc_inc=1 every cycle, no cmd_*; '[' -> depth+1; ']' with depth>1 -> depth-1; ']' with depth==1 -> depth<=0, next RUN; other opcodes (incl. HALT) ignored.
REQ-025 SKIP_BACK: pc_dec=1 every cycle except terminating cycle, no cmd_*; ']' -> depth+1; '[' with depth>1 -> depth-1; '[' with depth==1 -> pc_inc=1 (pc_dec=0), depth<=0, next RUN; other opcodes ignored.
REQ-026 Overflow: an increment when depth == 2^DEPTH_W-1 -> next ERROR, depth holds max value; no wrap-around.
REQ-027 RUN, HALT: all strobes 0, no PC movement, next HALT.
REQ-028 HALT: halted=1, all other pulse outputs 0, terminal until reset.
REQ-029 ERROR: error=1, all other pulse outputs 0, terminal until reset; error takes priority over halted (never both 1).
REQ-030 run_en=0 in any state: all pulse outputs 0, state and depth hold; halted/error levels unaffected.
REQ-031 Register update priority: rst_n=0 > run_en=0 > state logic.

Reset
REQ-032 rst_n sampled 0 at a rising edge -> state RESET, depth 0, halted 0, error 0, regardless of current state (including mid-skip, stall, HALT, ERROR).
REQ-033 While state is RESET, all outputs 0 independent of every input.

Verification
REQ-034 Reset release, instruction=0x1 held -> cycle 1 all outputs 0; cycle 2 cmd_data_inc=1, pc_inc=1.
REQ-035 RUN, '.' with ioready=0 for 3 cycles then 1 -> 3 cycles all outputs 0, 4th cycle cmd_out=1 and pc_inc=1, exactly once.
REQ-036 Program "[ [ + ] ] +" with zeroflag=1 at first '[' -> 5 cycles pc_inc only, depth sequence 1,2,2,1,0, then cmd_data_inc on final '+'.
REQ-037 Backward skip "[ + ]" at ']' with zeroflag=0 -> pc_dec, pc_dec, then pc_inc on '[', return to RUN with depth 0.
REQ-038 DEPTH_W=2, forward skip through 4 nested '[' -> depth reaches 3, next cycle error=1, all strobes 0; rst_n=0 for one edge clears error and depth.
REQ-039 HALT opcode then run_en toggling and rst_n=0 mid-skip -> halted=1 held with no strobes; reset returns to RESET then RUN with depth 0.

Source files
------------

// File: rtl/potato2_control.sv
// Control FSM for a Brainf*ck-style core: decodes the opcode at the current PC,
// issues datapath strobes and PC moves, and skips over loop bodies using a nesting counter.
module potato2_control #(
    parameter int DEPTH_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run_en,
    input  logic               ioready,
    input  logic               zeroflag,
    input  logic [3:0]         instruction,
    output logic               pc_inc,
    output logic               pc_dec,
    output logic               cmd_data_inc,
    output logic               cmd_data_dec,
    output logic               cmd_ptr_inc,
    output logic               cmd_ptr_dec,
    output logic               cmd_out,
    output logic               cmd_in,
    output logic               halted,
    output logic               error,
    output logic [DEPTH_W-1:0] depth
);

    localparam logic [2:0] ST_RESET     = 3'd0;
    localparam logic [2:0] ST_RUN       = 3'd1;
    localparam logic [2:0] ST_SKIP_FWD  = 3'd2;
    localparam logic [2:0] ST_SKIP_BACK = 3'd3;
    localparam logic [2:0] ST_HALT      = 3'd4;
    localparam logic [2:0] ST_ERROR     = 3'd5;

    localparam logic [3:0] OP_DATA_INC = 4'h1;
    localparam logic [3:0] OP_DATA_DEC = 4'h2;
    localparam logic [3:0] OP_PTR_INC  = 4'h3;
    localparam logic [3:0] OP_PTR_DEC  = 4'h4;
    localparam logic [3:0] OP_OPEN     = 4'h5;
    localparam logic [3:0] OP_CLOSE    = 4'h6;
    localparam logic [3:0] OP_OUT      = 4'h7;
    localparam logic [3:0] OP_IN       = 4'h8;
    localparam logic [3:0] OP_HALT     = 4'hF;

    localparam logic [DEPTH_W-1:0] DEPTH_ZERO = '0;
    localparam logic [DEPTH_W-1:0] DEPTH_ONE  = DEPTH_W'(1);
    localparam logic [DEPTH_W-1:0] DEPTH_MAX  = '1;

    logic [2:0]         state_q, state_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;

    always_comb begin
        state_d      = state_q;
        depth_d      = depth_q;
        pc_inc       = 1'b0;
        pc_dec       = 1'b0;
        cmd_data_inc = 1'b0;
        cmd_data_dec = 1'b0;
        cmd_ptr_inc  = 1'b0;
        cmd_ptr_dec  = 1'b0;
        cmd_out      = 1'b0;
        cmd_in       = 1'b0;
        if (run_en) begin
            case (state_q)
                ST_RESET: begin
                    state_d = ST_RUN;
                    depth_d = DEPTH_ZERO;
                end
                ST_RUN: begin
                    case (instruction)
                        OP_DATA_INC: begin cmd_data_inc = 1'b1; pc_inc = 1'b1; end
                        OP_DATA_DEC: begin cmd_data_dec = 1'b1; pc_inc = 1'b1; end
                        OP_PTR_INC:  begin cmd_ptr_inc  = 1'b1; pc_inc = 1'b1; end
                        OP_PTR_DEC:  begin cmd_ptr_dec  = 1'b1; pc_inc = 1'b1; end
                        // I/O stalls in place until the external side is ready
                        OP_OUT: begin
                            cmd_out = ioready;
                            pc_inc  = ioready;
                        end
                        OP_IN: begin
                            cmd_in = ioready;
                            pc_inc = ioready;
                        end
                        OP_OPEN: begin
                            pc_inc = 1'b1;
                            if (zeroflag) begin
                                depth_d = DEPTH_ONE;
                                state_d = ST_SKIP_FWD;
                            end
                        end
                        OP_CLOSE: begin
                            if (zeroflag) begin
                                pc_inc = 1'b1;
                            end else begin
                                pc_dec  = 1'b1;
                                depth_d = DEPTH_ONE;
                                state_d = ST_SKIP_BACK;
                            end
                        end
                        OP_HALT: state_d = ST_HALT;
                        default: pc_inc = 1'b1;
                    endcase
                end
                ST_SKIP_FWD: begin
                    pc_inc = 1'b1;
                    if (instruction == OP_OPEN) begin
                        if (depth_q == DEPTH_MAX) state_d = ST_ERROR;
                        else                      depth_d = depth_q + DEPTH_ONE;
                    end else if (instruction == OP_CLOSE) begin
                        depth_d = depth_q - DEPTH_ONE;
                        if (depth_q == DEPTH_ONE) state_d = ST_RUN;
                    end
                end
                ST_SKIP_BACK: begin
                    // The matching '[' ends the scan and steps forward past it
                    if (instruction == OP_OPEN && depth_q == DEPTH_ONE) begin
                        pc_inc  = 1'b1;
                        depth_d = DEPTH_ZERO;
                        state_d = ST_RUN;
                    end else begin
                        pc_dec = 1'b1;
                        if (instruction == OP_CLOSE) begin
                            if (depth_q == DEPTH_MAX) state_d = ST_ERROR;
                            else                      depth_d = depth_q + DEPTH_ONE;
                        end else if (instruction == OP_OPEN) begin
                            depth_d = depth_q - DEPTH_ONE;
                        end
                    end
                end
                ST_HALT:  state_d = ST_HALT;
                ST_ERROR: state_d = ST_ERROR;
                default:  state_d = ST_RESET;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_RESET;
            depth_q <= DEPTH_ZERO;
        end else begin
            state_q <= state_d;
            depth_q <= depth_d;
        end
    end

    assign halted = (state_q == ST_HALT);
    assign error  = (state_q == ST_ERROR);
    assign depth  = depth_q;

endmodule

// File: tb/tb_potato2_control.sv
// Bench for potato2_control: directed loop/IO/halt/overflow scenarios plus a randomized
// run checked against an interpreter-level model of the control rules.
module tb_potato2_control;

    localparam int DW = 2;

    localparam logic [9:0] PCI  = 10'h200;
    localparam logic [9:0] PCD  = 10'h100;
    localparam logic [9:0] DINC = 10'h080;
    localparam logic [9:0] OUTS = 10'h008;
    localparam logic [9:0] INS  = 10'h004;
    localparam logic [9:0] HLT  = 10'h002;
    localparam logic [9:0] ERR  = 10'h001;

    localparam int M_RESET = 0, M_RUN = 1, M_FWD = 2, M_BACK = 3, M_HALT = 4, M_ERR = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          run_en = 1'b0;
    logic          ioready = 1'b0;
    logic          zeroflag = 1'b0;
    logic [3:0]    instruction = 4'h0;
    logic          pc_inc, pc_dec, cmd_data_inc, cmd_data_dec, cmd_ptr_inc, cmd_ptr_dec;
    logic          cmd_out, cmd_in, halted, error;
    logic [DW-1:0] depth;
    logic [9:0]    outs;

    int vectors = 0;
    int miscompares = 0;

    potato2_control #(.DEPTH_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .run_en(run_en), .ioready(ioready), .zeroflag(zeroflag),
        .instruction(instruction), .pc_inc(pc_inc), .pc_dec(pc_dec),
        .cmd_data_inc(cmd_data_inc), .cmd_data_dec(cmd_data_dec),
        .cmd_ptr_inc(cmd_ptr_inc), .cmd_ptr_dec(cmd_ptr_dec),
        .cmd_out(cmd_out), .cmd_in(cmd_in), .halted(halted), .error(error), .depth(depth)
    );

    assign outs = {pc_inc, pc_dec, cmd_data_inc, cmd_data_dec, cmd_ptr_inc, cmd_ptr_dec,
                   cmd_out, cmd_in, halted, error};

    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are sampled 1 ns later
    task automatic drive(input logic r, input logic e, input logic io, input logic zf,
                         input logic [3:0] ins);
        @(negedge clk);
        rst_n = r; run_en = e; ioready = io; zeroflag = zf; instruction = ins;
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
    endtask

    // Interpreter-level rules: what the core should do this cycle
    function automatic logic [9:0] model_out(int mode, int dep, bit en, bit io, bit zf, int op);
        logic [9:0] o;
        o = '0;
        if (mode == M_HALT) o = HLT;
        if (mode == M_ERR)  o = ERR;
        if (!en) return o;
        case (mode)
            M_RUN: begin
                if (op >= 1 && op <= 4)      o = (DINC >> (op - 1)) | PCI;
                else if (op == 7)            o = io ? (OUTS | PCI) : '0;
                else if (op == 8)            o = io ? (INS | PCI) : '0;
                else if (op == 6)            o = zf ? PCI : PCD;
                else if (op == 15)           o = '0;
                else                         o = PCI;
            end
            M_FWD:  o = PCI;
            M_BACK: o = (op == 5 && dep == 1) ? PCI : PCD;
            default: ;
        endcase
        return o;
    endfunction

    task automatic model_step(inout int mode, inout int dep, input bit r, input bit en,
                              input bit zf, input int op);
        int dmax;
        dmax = (1 << DW) - 1;
        if (!r) begin
            mode = M_RESET; dep = 0;
        end else if (en) begin
            case (mode)
                M_RESET: mode = M_RUN;
                M_RUN: begin
                    if (op == 5 && zf)       begin dep = 1; mode = M_FWD;  end
                    else if (op == 6 && !zf) begin dep = 1; mode = M_BACK; end
                    else if (op == 15)       mode = M_HALT;
                end
                M_FWD, M_BACK: begin
                    int deeper, shallower;
                    deeper    = (mode == M_FWD) ? 5 : 6;
                    shallower = (mode == M_FWD) ? 6 : 5;
                    if (op == deeper) begin
                        if (dep == dmax) mode = M_ERR;
                        else             dep = dep + 1;
                    end else if (op == shallower) begin
                        dep = dep - 1;
                        if (dep == 0) mode = M_RUN;
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom));
            if (i > 0) begin
                vectors++;
                if (outs !== 10'h000) begin
                    miscompares++;
                    $display("FAIL reset_outs: got %h want %h", outs, 10'h000);
                end
                vectors++;
                if (depth !== '0) begin
                    miscompares++;
                    $display("FAIL reset_depth: got %0d want 0", depth);
                end
            end
        end
        // First cycle after release is idle, the held '+' executes on the second
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'h1);
        vectors++;
        if (outs !== 10'h000) begin
            miscompares++;
            $display("FAIL release_cycle1: got %h want %h", outs, 10'h000);
        end
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'h1);
        vectors++;
        if (outs !== (DINC | PCI)) begin
            miscompares++;
            $display("FAIL release_cycle2: got %h want %h", outs, DINC | PCI);
        end
    endtask

    task automatic test_io_stall();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            logic [9:0] exp;
            exp = (i < 3) ? 10'h000 : (OUTS | PCI);
            drive(1'b1, 1'b1, (i == 3), 1'($urandom), 4'h7);
            vectors++;
            if (outs !== exp) begin
                miscompares++;
                $display("FAIL io_stall cycle%0d: got %h want %h", i, outs, exp);
            end
        end
        drive(1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
        vectors++;
        if (outs !== PCI) begin
            miscompares++;
            $display("FAIL io_after: got %h want %h", outs, PCI);
        end
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'h8);
        vectors++;
        if (outs !== 10'h000) begin
            miscompares++;
            $display("FAIL in_stall: got %h want %h", outs, 10'h000);
        end
        drive(1'b1, 1'b1, 1'b1, 1'b0, 4'h8);
        vectors++;
        if (outs !== (INS | PCI)) begin
            miscompares++;
            $display("FAIL in_ready: got %h want %h", outs, INS | PCI);
        end
    endtask

    task automatic test_nested_skip();
        logic [3:0] prog [6]  = '{4'h5, 4'h5, 4'h1, 4'h6, 4'h6, 4'h1};
        logic [9:0] eo   [6]  = '{PCI, PCI, PCI, PCI, PCI, DINC | PCI};
        int         ed   [6]  = '{0, 1, 2, 2, 1, 0};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b1, 1'b0, (i == 0) ? 1'b1 : 1'($urandom), prog[i]);
            vectors++;
            if (outs !== eo[i] || depth !== DW'(ed[i])) begin
                miscompares++;
                $display("FAIL fwd_skip step%0d: got out %h depth %0d want out %h depth %0d",
                         i, outs, depth, eo[i], ed[i]);
            end
        end
    endtask

    task automatic test_back_skip();
        logic [3:0] prog [4] = '{4'h6, 4'h1, 4'h5, 4'h0};
        logic [9:0] eo   [4] = '{PCD, PCD, PCI, PCI};
        int         ed   [4] = '{0, 1, 1, 0};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 1'b0, (i == 0) ? 1'b0 : 1'($urandom), prog[i]);
            vectors++;
            if (outs !== eo[i] || depth !== DW'(ed[i])) begin
                miscompares++;
                $display("FAIL back_skip step%0d: got out %h depth %0d want out %h depth %0d",
                         i, outs, depth, eo[i], ed[i]);
            end
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b1, 4'h5);
            vectors++;
            if (outs !== PCI || depth !== DW'(i)) begin
                miscompares++;
                $display("FAIL ovf_nest%0d: got out %h depth %0d want out %h depth %0d",
                         i, outs, depth, PCI, i);
            end
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b0, (i == 0) ? 4'h5 : 4'h1);
            vectors++;
            if (outs !== ERR || depth !== DW'(3)) begin
                miscompares++;
                $display("FAIL ovf_error%0d: got out %h depth %0d want out %h depth 3",
                         i, outs, depth, ERR);
            end
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 4'h1);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'h1);
        vectors++;
        if (outs !== 10'h000 || depth !== '0) begin
            miscompares++;
            $display("FAIL ovf_clear: got out %h depth %0d want out 000 depth 0", outs, depth);
        end
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'h1);
        vectors++;
        if (outs !== (DINC | PCI)) begin
            miscompares++;
            $display("FAIL ovf_resume: got %h want %h", outs, DINC | PCI);
        end
    endtask

    task automatic test_halt_freeze();
        do_reset();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 4'hF);
        vectors++;
        if (outs !== 10'h000) begin
            miscompares++;
            $display("FAIL halt_issue: got %h want %h", outs, 10'h000);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'(i), 1'b1, 1'($urandom), 4'($urandom_range(1, 8)));
            vectors++;
            if (outs !== HLT) begin
                miscompares++;
                $display("FAIL halt_hold%0d: got %h want %h", i, outs, HLT);
            end
        end
        do_reset();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 4'h1);
        vectors++;
        if (outs !== 10'h000) begin
            miscompares++;
            $display("FAIL freeze_run: got %h want %h", outs, 10'h000);
        end
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 4'h5);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 4'h5);
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b1, 4'h6);
            vectors++;
            if (outs !== 10'h000 || depth !== DW'(2)) begin
                miscompares++;
                $display("FAIL freeze_skip%0d: got out %h depth %0d want out 000 depth 2",
                         i, outs, depth);
            end
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 4'h5);
        vectors++;
        if (outs !== PCI || depth !== DW'(2)) begin
            miscompares++;
            $display("FAIL midskip_rst: got out %h depth %0d want out %h depth 2", outs, depth, PCI);
        end
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
        vectors++;
        if (outs !== 10'h000 || depth !== '0) begin
            miscompares++;
            $display("FAIL midskip_reset_state: got out %h depth %0d want out 000 depth 0",
                     outs, depth);
        end
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
        vectors++;
        if (outs !== PCI || depth !== '0) begin
            miscompares++;
            $display("FAIL midskip_run: got out %h depth %0d want out %h depth 0", outs, depth, PCI);
        end
    endtask

    task automatic test_random();
        int mode, dep, op, sel;
        bit r, en, io, zf;
        logic [9:0] exp;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
        mode = M_RESET; dep = 0;
        for (int i = 0; i < 600; i++) begin
            sel = $urandom_range(0, 9);
            if (sel < 3)      op = 5;
            else if (sel < 5) op = 6;
            else              op = $urandom_range(0, 15);
            r  = ($urandom_range(0, 24) != 0);
            en = ($urandom_range(0, 7) != 0);
            io = 1'($urandom);
            zf = 1'($urandom);
            drive(r, en, io, zf, 4'(op));
            exp = model_out(mode, dep, en, io, zf, op);
            vectors++;
            if (outs !== exp || depth !== DW'(dep)) begin
                miscompares++;
                $display("FAIL random%0d op %0h: got out %h depth %0d want out %h depth %0d",
                         i, op, outs, depth, exp, dep);
            end
            model_step(mode, dep, r, en, zf, op);
        end
    endtask

    initial begin
        test_reset();
        test_io_stall();
        test_nested_skip();
        test_back_skip();
        test_overflow();
        test_halt_freeze();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
